// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared defaults and stage-1 control record for mac_pipe
package mac_pkg;

  localparam int MAC_WIDTH = 16;
  localparam int MAC_ACCW  = 2 * MAC_WIDTH + 8;
  localparam int MAC_CNTW  = 8;

  // Framing and mode bits that travel with the registered product.
  // The product is kept beside this record because its width follows WIDTH.
  typedef struct packed {
    logic first;
    logic last;
    logic sgn;
  } s1_ctrl_t;

endpackage

// File: rtl/mac_acc_stage.sv
// rtl/mac_acc_stage.sv - extend, accumulate, overflow and term-count logic
module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH,
  parameter int ACCW  = MAC_ACCW,
  parameter int CNTW  = MAC_CNTW
) (
  input  logic [2*WIDTH-1:0] product,
  input  logic               sgn,
  input  logic               restart,
  input  logic [ACCW-1:0]    acc,
  input  logic [CNTW-1:0]    cnt,
  input  logic               ovf,
  output logic [ACCW-1:0]    acc_next,
  output logic [CNTW-1:0]    cnt_next,
  output logic               ovf_next
);

  logic [ACCW-1:0] ext;
  logic [ACCW-1:0] base;
  logic [ACCW:0]   sum_w;
  logic            elem_ovf;

  // Add one element onto the running sum (or onto zero when a frame restarts).
  always_comb begin
    ext      = sgn ? ACCW'($signed(product)) : ACCW'(product);
    base     = restart ? '0 : acc;
    sum_w    = {1'b0, base} + {1'b0, ext};
    acc_next = sum_w[ACCW-1:0];
    if (sgn) begin
      elem_ovf = (base[ACCW-1] == ext[ACCW-1]) && (sum_w[ACCW-1] != base[ACCW-1]);
    end else begin
      elem_ovf = sum_w[ACCW];
    end
    if (restart) begin
      cnt_next = CNTW'(1);
    end else if (cnt == {CNTW{1'b1}}) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CNTW'(1);
    end
    ovf_next = (ovf && !restart) || elem_ovf;
  end

endmodule

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - two-stage streaming multiply-accumulate with framed results
module mac_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH,
  parameter int ACCW  = 2 * WIDTH + 8,
  parameter int CNTW  = MAC_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             first,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACCW-1:0]  acc_q,
  output logic [CNTW-1:0]  count_q,
  output logic             ovf_q
);

  if (ACCW < 2 * WIDTH) begin : g_accw_check
    $error("mac_pipe: ACCW must be at least 2*WIDTH");
  end

  logic [2*WIDTH-1:0] prod_q, prod_d;
  s1_ctrl_t           ctrl_q, ctrl_d;
  logic               v1_q, v1_d;
  logic [ACCW-1:0]    run_acc_q, run_acc_d;
  logic [CNTW-1:0]    run_cnt_q, run_cnt_d;
  logic               run_ovf_q, run_ovf_d;
  logic               ended_q, ended_d;
  logic [ACCW-1:0]    acc_d;
  logic [CNTW-1:0]    count_d;
  logic               ovf_d;
  logic               out_valid_q, out_valid_d;

  logic               adv;
  logic               accept;
  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic [ACCW-1:0]    acc_next;
  logic [CNTW-1:0]    cnt_next;
  logic               ovf_next;

  // A held result is the only thing that stalls the whole pipe.
  assign adv       = !(out_valid_q && !out_ready);
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign out_valid = out_valid_q;

  mac_acc_stage #(
    .WIDTH (WIDTH),
    .ACCW  (ACCW),
    .CNTW  (CNTW)
  ) u_acc_stage (
    .product  (prod_q),
    .sgn      (ctrl_q.sgn),
    .restart  (ctrl_q.first || ended_q),
    .acc      (run_acc_q),
    .cnt      (run_cnt_q),
    .ovf      (run_ovf_q),
    .acc_next (acc_next),
    .cnt_next (cnt_next),
    .ovf_next (ovf_next)
  );

  // Next-state for product register, running sum and result register.
  always_comb begin
    prod_d      = prod_q;
    ctrl_d      = ctrl_q;
    v1_d        = v1_q;
    run_acc_d   = run_acc_q;
    run_cnt_d   = run_cnt_q;
    run_ovf_d   = run_ovf_q;
    ended_d     = ended_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    // Extending both operands to 2*WIDTH lets one multiplier serve both modes.
    a_ext = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext = signed_mode ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};

    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (adv) begin
      v1_d = accept;
      if (accept) begin
        prod_d = a_ext * b_ext;
        ctrl_d = '{first: first, last: last, sgn: signed_mode};
      end
      if (v1_q) begin
        run_acc_d = acc_next;
        run_cnt_d = cnt_next;
        run_ovf_d = ovf_next;
        ended_d   = ctrl_q.last;
        if (ctrl_q.last) begin
          acc_d       = acc_next;
          count_d     = cnt_next;
          ovf_d       = ovf_next;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // Pipeline state; the sum starts out as if a frame had just ended.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q      <= '0;
      ctrl_q      <= '0;
      v1_q        <= 1'b0;
      run_acc_q   <= '0;
      run_cnt_q   <= '0;
      run_ovf_q   <= 1'b0;
      ended_q     <= 1'b1;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      ctrl_q      <= ctrl_d;
      v1_q        <= v1_d;
      run_acc_q   <= run_acc_d;
      run_cnt_q   <= run_cnt_d;
      run_ovf_q   <= run_ovf_d;
      ended_q     <= ended_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
